inst_envelope: RTL and testbench



---
 rtl/inst_envelope_if.sv | 26 ++
 rtl/inst_envelope.sv | 142 ++++++++++++++
 tb/tb_inst_envelope.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_envelope_if.sv
// Hit-event handshake between a drum trigger source and the envelope block.
// The source is the master; the envelope generator is the slave.
interface inst_envelope_if #(
    parameter int INSTRUMENT_COUNT = 3
);
    localparam int IW = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1;

    logic          hit_valid;
    logic          hit_ready;
    logic [IW-1:0] hit_inst;
    logic [6:0]    hit_velocity;

    modport master (
        output hit_valid,
        output hit_inst,
        output hit_velocity,
        input  hit_ready
    );

    modport slave (
        input  hit_valid,
        input  hit_inst,
        input  hit_velocity,
        output hit_ready
    );
endinterface

// File: rtl/inst_envelope.sv
// Per-instrument hit envelope: velocity hits become {active, level} bytes that
// hold for a few frames and then decay, updating once per video frame.
module inst_envelope #(
    parameter int INSTRUMENT_COUNT = 3,
    parameter int HOLD_FRAMES      = 2,
    parameter int SNAPSHOT_V       = 721
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [10:0]                       h_count,
    input  logic [9:0]                        v_count,
    inst_envelope_if.slave                    hit,
    input  logic [9:0]                        decay_rate,
    output logic [INSTRUMENT_COUNT-1:0][7:0]  inst_intensity
);
    localparam int IW = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(1);
    localparam logic [IW:0]   INST_LIMIT = (IW + 1)'(INSTRUMENT_COUNT);
    localparam logic [9:0]    TICK_LINE  = 10'(SNAPSHOT_V - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } state_t;

    logic       tick_cmp;
    logic       tick_reg;
    logic       hit_ready_reg;
    logic       hit_take;
    logic [7:0] rate;
    logic       unused_rate_bits;

    // The raster compare is registered, so the frame tick is the cycle after the
    // counters read (0, SNAPSHOT_V-1); hit_ready drops for exactly that cycle.
    assign tick_cmp = (h_count == 11'd0) && (v_count == TICK_LINE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_reg      <= 1'b0;
            hit_ready_reg <= 1'b0;
        end else begin
            tick_reg      <= tick_cmp;
            hit_ready_reg <= !tick_cmp;
        end
    end

    assign hit.hit_ready    = hit_ready_reg;
    assign rate             = decay_rate[9:2];
    assign unused_rate_bits = ^decay_rate[1:0];

    // Out-of-range instruments and zero-velocity hits are accepted but dropped.
    assign hit_take = hit.hit_valid && hit_ready_reg &&
                      ({1'b0, hit.hit_inst} < INST_LIMIT) &&
                      (hit.hit_velocity != 7'd0);

    generate
        for (genvar gi = 0; gi < INSTRUMENT_COUNT; gi++) begin : g_inst
            state_t        state_reg,   state_next;
            logic [6:0]    level_reg,   level_next;
            logic [6:0]    pending_reg, pending_next;
            logic          pflag_reg,   pflag_next;
            logic [HW-1:0] hold_reg,    hold_next;
            logic [7:0]    intensity_reg;
            logic [14:0]   dec_prod;
            logic [6:0]    dec;
            logic [6:0]    step;
            logic          hit_here;

            assign hit_here = hit_take && (hit.hit_inst == IW'(gi));
            assign dec_prod = {8'd0, level_reg} * {7'd0, rate};
            assign dec      = 7'(dec_prod >> 8);
            assign step     = (dec == 7'd0) ? 7'd1 : dec;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg     <= IDLE;
                    level_reg     <= 7'd0;
                    pending_reg   <= 7'd0;
                    pflag_reg     <= 1'b0;
                    hold_reg      <= '0;
                    intensity_reg <= 8'd0;
                end else begin
                    state_reg   <= state_next;
                    level_reg   <= level_next;
                    pending_reg <= pending_next;
                    pflag_reg   <= pflag_next;
                    hold_reg    <= hold_next;
                    if (tick_reg) begin
                        intensity_reg <= {(state_next != IDLE) && (level_next != 7'd0), level_next};
                    end
                end
            end

            always_comb begin
                state_next   = state_reg;
                level_next   = level_reg;
                pending_next = pending_reg;
                pflag_next   = pflag_reg;
                hold_next    = hold_reg;
                if (tick_reg) begin
                    if (pflag_reg) begin
                        // A retrigger always wins, even with a lower velocity.
                        level_next   = pending_reg;
                        hold_next    = HOLD_LOAD;
                        state_next   = HOLD;
                        pflag_next   = 1'b0;
                        pending_next = 7'd0;
                    end else begin
                        case (state_reg)
                            HOLD: begin
                                if (hold_reg == HOLD_LAST) begin
                                    state_next = DECAY;
                                end else begin
                                    hold_next = hold_reg - HOLD_LAST;
                                end
                            end
                            DECAY: begin
                                if (level_reg <= step) begin
                                    level_next = 7'd0;
                                    state_next = IDLE;
                                end else begin
                                    level_next = level_reg - step;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end else if (hit_here) begin
                    pending_next = (pflag_reg && (pending_reg > hit.hit_velocity)) ?
                                   pending_reg : hit.hit_velocity;
                    pflag_next   = 1'b1;
                end
            end

            assign inst_intensity[gi] = intensity_reg;
        end
    endgenerate
endmodule

// File: tb/tb_inst_envelope.sv
// Scoreboard bench for inst_envelope: a frame-level envelope model predicts each
// post-tick output vector; a negedge monitor pops and compares.
module tb_inst_envelope;
    localparam int N    = 3;
    localparam int HOLD = 2;
    localparam int SNAP = 721;

    typedef logic [N-1:0][7:0] vec_t;
    typedef struct {
        int level;
        int pending;
        bit pflag;
        bit active;
        int age;
    } mst_t;
    typedef mst_t st_arr_t [N];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic [9:0]  decay_rate;
    vec_t        inst_intensity;

    inst_envelope_if #(.INSTRUMENT_COUNT(N)) hif();

    inst_envelope #(
        .INSTRUMENT_COUNT(N),
        .HOLD_FRAMES(HOLD),
        .SNAPSHOT_V(SNAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .h_count(h_count),
        .v_count(v_count),
        .hit(hif),
        .decay_rate(decay_rate),
        .inst_intensity(inst_intensity)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Envelope model: a triggered level is shown for HOLD+1 frames, then each
    // frame drops by max(level*rate/256, 1) until it reaches zero.
    function automatic mst_t m_tick(input mst_t s, input int r);
        mst_t n;
        int   st;
        n = s;
        if (s.pflag) begin
            n.level   = s.pending;
            n.pending = 0;
            n.pflag   = 1'b0;
            n.active  = 1'b1;
            n.age     = 0;
        end else if (s.active) begin
            n.age = s.age + 1;
            if (n.age > HOLD) begin
                st = (s.level * r) / 256;
                if (st < 1) st = 1;
                if (s.level <= st) begin
                    n.level  = 0;
                    n.active = 1'b0;
                end else begin
                    n.level = s.level - st;
                end
            end
        end
        return n;
    endfunction

    function automatic mst_t m_accept(input mst_t s, input int vel);
        mst_t n;
        n = s;
        n.pending = (s.pflag && s.pending > vel) ? s.pending : vel;
        n.pflag   = 1'b1;
        return n;
    endfunction

    function automatic st_arr_t m_tick_all(input st_arr_t a, input int r);
        st_arr_t n;
        for (int i = 0; i < N; i++) n[i] = m_tick(a[i], r);
        return n;
    endfunction

    function automatic vec_t m_expect(input st_arr_t a);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = {a[i].active && (a[i].level != 0), 7'(a[i].level)};
        return v;
    endfunction

    st_arr_t m_st;
    logic    m_ready;
    logic    m_tick_now;
    logic    out_due;
    vec_t    exp_q [$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) m_st[i] <= '{0, 0, 1'b0, 1'b0, 0};
            m_ready    <= 1'b0;
            m_tick_now <= 1'b0;
            out_due    <= 1'b0;
            exp_q.delete();
        end else begin
            out_due <= m_tick_now;
            if (m_tick_now) begin
                m_st <= m_tick_all(m_st, int'(decay_rate[9:2]));
                exp_q.push_back(m_expect(m_tick_all(m_st, int'(decay_rate[9:2]))));
            end else if (m_ready && hif.hit_valid && (int'(hif.hit_inst) < N) &&
                         (hif.hit_velocity != 7'd0)) begin
                m_st[hif.hit_inst] <= m_accept(m_st[hif.hit_inst], int'(hif.hit_velocity));
            end
            m_ready    <= !((h_count == 11'd0) && (v_count == 10'(SNAP - 1)));
            m_tick_now <=  (h_count == 11'd0) && (v_count == 10'(SNAP - 1));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("hit_ready", 32'(hif.hit_ready), 32'(m_ready));
            if (out_due) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'(1), 32'(0));
                end else begin
                    chk("inst_intensity", 32'(inst_intensity), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic do_tick();
        @(negedge clk);
        h_count = 11'd0;
        v_count = 10'(SNAP - 1);
        @(negedge clk);
        h_count = 11'd1;
        @(negedge clk);
        h_count = 11'd5;
        v_count = 10'd100;
    endtask

    task automatic send_hit(input int inst, input int vel);
        @(negedge clk);
        hif.hit_valid    = 1'b1;
        hif.hit_inst     = 2'(inst);
        hif.hit_velocity = 7'(vel);
        @(negedge clk);
        hif.hit_valid = 1'b0;
    endtask

    logic [7:0] t2_exp [11] = '{8'hE4, 8'hE4, 8'hE4, 8'hB2, 8'h99, 8'h8D, 8'h87, 8'h84, 8'h82, 8'h81, 8'h00};
    logic [7:0] t4_exp [8]  = '{8'h85, 8'h85, 8'h85, 8'h84, 8'h83, 8'h82, 8'h81, 8'h00};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        h_count          = 11'd5;
        v_count          = 10'd100;
        decay_rate       = 10'd512;
        hif.hit_valid    = 1'b0;
        hif.hit_inst     = 2'd0;
        hif.hit_velocity = 7'd0;
        #1;
        chk("reset_intensity", 32'(inst_intensity), 32'(0));
        chk("reset_ready", 32'(hif.hit_ready), 32'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", 32'(hif.hit_ready), 32'(1));

        // Single hit, hold then decay at rate 128/256
        send_hit(1, 100);
        for (int k = 0; k < 11; k++) begin
            do_tick();
            chk("t2_inst1", 32'(inst_intensity[1]), 32'(t2_exp[k]));
            chk("t2_others", 32'({inst_intensity[2], inst_intensity[0]}), 32'(0));
        end

        // Same-frame hits keep the max; a lower retrigger mid-decay restarts hold
        send_hit(0, 40);
        send_hit(0, 90);
        do_tick();
        chk("t3_max_up", 32'(inst_intensity[0]), 32'h0DA);
        send_hit(0, 90);
        send_hit(0, 40);
        do_tick();
        chk("t3_max_down", 32'(inst_intensity[0]), 32'h0DA);
        send_hit(2, 100);
        repeat (4) do_tick();
        chk("t3_level50", 32'(inst_intensity[2]), 32'h0B2);
        send_hit(2, 20);
        do_tick();
        chk("t3_retrig", 32'(inst_intensity[2]), 32'h094);
        repeat (2) do_tick();
        chk("t3_hold", 32'(inst_intensity[2]), 32'h094);
        do_tick();
        chk("t3_decay", 32'(inst_intensity[2]), 32'h08A);

        // Asynchronous reset mid-decay clears outputs with no clock edge
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_intensity", 32'(inst_intensity), 32'(0));
        chk("async_rst_ready", 32'(hif.hit_ready), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rerelease", 32'(hif.hit_ready), 32'(1));

        // Zero decay rate still steps by one
        decay_rate = 10'd0;
        send_hit(1, 5);
        for (int k = 0; k < 8; k++) begin
            do_tick();
            chk("t4_inst1", 32'(inst_intensity[1]), 32'(t4_exp[k]));
        end

        // All three instruments in one frame
        send_hit(0, 10);
        send_hit(1, 20);
        send_hit(2, 30);
        do_tick();
        chk("t6_all", 32'(inst_intensity), 32'h9E948A);

        // Discarded hits: out-of-range index and zero velocity
        send_hit(3, 127);
        send_hit(0, 0);
        do_tick();
        chk("t5_discard", 32'(inst_intensity), 32'h9E948A);

        // Hit offered only in the tick cycle must be refused
        @(negedge clk);
        h_count = 11'd0;
        v_count = 10'(SNAP - 1);
        @(negedge clk);
        chk("t5_ready_tick", 32'(hif.hit_ready), 32'(0));
        h_count          = 11'd1;
        hif.hit_valid    = 1'b1;
        hif.hit_inst     = 2'd0;
        hif.hit_velocity = 7'd127;
        @(negedge clk);
        chk("t5_ready_after", 32'(hif.hit_ready), 32'(1));
        hif.hit_valid = 1'b0;
        h_count       = 11'd5;
        v_count       = 10'd100;
        chk("t5_tick_hit_unchanged", 32'(inst_intensity), 32'h9E948A);
        do_tick();
        chk("t5_first_decay", 32'(inst_intensity), 32'h9D9389);

        // Randomized frames: hits, held valids across ticks, mid-frame rate changes
        for (int f = 0; f < 80; f++) begin
            int ncyc;
            ncyc = int'($urandom_range(2, 8));
            for (int c = 0; c < ncyc; c++) begin
                int sel;
                @(negedge clk);
                if ($urandom_range(0, 2) == 0) begin
                    hif.hit_valid    = 1'b1;
                    hif.hit_inst     = 2'($urandom_range(0, 3));
                    hif.hit_velocity = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
                end else if ($urandom_range(0, 3) != 0) begin
                    hif.hit_valid = 1'b0;
                end
                if ($urandom_range(0, 5) == 0) decay_rate = 10'($urandom_range(0, 1023));
                sel = int'($urandom_range(0, 2));
                if (sel == 0) begin
                    h_count = 11'd0;
                    v_count = 10'(SNAP - 2);
                end else if (sel == 1) begin
                    h_count = 11'($urandom_range(1, 1279));
                    v_count = 10'(SNAP - 1);
                end else begin
                    h_count = 11'($urandom_range(0, 1279));
                    v_count = 10'($urandom_range(0, SNAP - 3));
                end
            end
            @(negedge clk);
            h_count = 11'd0;
            v_count = 10'(SNAP - 1);
            @(negedge clk);
            h_count = 11'd3;
            if ($urandom_range(0, 1) == 0) hif.hit_valid = 1'b0;
        end
        @(negedge clk);
        hif.hit_valid = 1'b0;
        repeat (3) do_tick();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
